// File: rtl/seq_booth_multiplier.sv
// seq_booth_multiplier: sequential Booth multiplier, signed/unsigned per operation, valid/ready on both sides
// Optional feature macro: BOOTH_RADIX4_EN (radix-4 modified Booth, ITER = N/2+1; default radix-2, ITER = N+1)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (accepted in IDLE only)
//   in_signed             1: two's complement operands, 0: unsigned
//   multiplicand [N-1:0]  operand A
//   multiplier   [N-1:0]  operand B (recoded operand)
//   out_valid / out_ready result handshake
//   product [2N-1:0]      exact A*B, held until the next completion
module seq_booth_multiplier #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_signed,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);
    // Operands are extended to N+2 bits so unsigned values become positive signed values;
    // one extra accumulator bit absorbs +-2A without overflow.
    localparam int W  = N + 2;
    localparam int AW = N + 3;
    localparam int CW = $clog2(N + 2);
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = N / 2 + 1;
`else
    localparam int ITER = N + 1;
`endif
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nxt;
    logic [W-1:0]         a, q;
    logic                 q_1, q_1_nxt;
    logic signed [AW-1:0] acc, a_x, sum;
    logic [AW+W-1:0]      shifted;
    logic [2*N-1:0]       res;
    logic [CW-1:0]        cnt;

    assign a_x = {a[W-1], a};

`ifdef BOOTH_RADIX4_EN
    always_comb begin
        case ({q[1:0], q_1})
            3'b001, 3'b010: sum = acc + a_x;
            3'b011:         sum = acc + (a_x <<< 1);
            3'b100:         sum = acc - (a_x <<< 1);
            3'b101, 3'b110: sum = acc - a_x;
            default:        sum = acc;
        endcase
        shifted = $signed({sum, q}) >>> 2;
        q_1_nxt = q[1];
    end
    // All N+2 recoded bits have been consumed, so the product sits at the bottom.
    assign res = shifted[2*N-1:0];
`else
    always_comb begin
        sum     = (q[0] == q_1) ? acc : (q[0] ? acc - a_x : acc + a_x);
        shifted = $signed({sum, q}) >>> 1;
        q_1_nxt = q[0];
    end
    // N+1 steps leave the unused top extension bit of Q in bit 0.
    assign res = shifted[2*N:1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = CALC;
            end
            CALC: if (cnt == CW'(1)) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a       <= '0;
            q       <= '0;
            q_1     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (state == IDLE && in_valid) begin
            a   <= in_signed ? {{2{multiplicand[N-1]}}, multiplicand} : {2'b00, multiplicand};
            q   <= in_signed ? {{2{multiplier[N-1]}}, multiplier} : {2'b00, multiplier};
            q_1 <= 1'b0;
            acc <= '0;
            cnt <= CW'(ITER);
        end else if (state == CALC) begin
            acc <= shifted[AW+W-1:W];
            q   <= shifted[W-1:0];
            q_1 <= q_1_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) product <= res;
        end
    end
endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb_seq_booth_multiplier: randomized and directed check of seq_booth_multiplier against an arithmetic reference
module tb_seq_booth_multiplier;
    localparam int N = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int ITER = N / 2 + 1;
`else
    localparam int ITER = N + 1;
`endif
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           in_signed = 1'b0;
    logic [N-1:0]   mcand = '0;
    logic [N-1:0]   mplier = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] product;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_booth_multiplier #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .multiplicand(mcand), .multiplier(mplier),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*N-1:0] ref_mul(input bit s, input logic [N-1:0] a, input logic [N-1:0] b);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end
        return (2*N)'(x * y);
    endfunction

    function automatic logic [N-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(N-1){1'b0}}};
            3: return {1'b0, {(N-1){1'b1}}};
            default: return N'($urandom);
        endcase
    endfunction

    task automatic run_op(input bit s, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int stall, input logic [2*N-1:0] exp);
        int lat;
        logic [2*N-1:0] p;
        in_valid = 1'b1; in_signed = s; mcand = a; mplier = b;
        @(posedge clk); #1;
        lat = 0;
        while (!out_valid && lat < ITER + 4) begin
            in_valid = 1'($urandom_range(0, 1)); in_signed = 1'($urandom_range(0, 1));
            mcand = N'($urandom); mplier = N'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 64'(lat), 64'(ITER));
        chk("product", product, exp);
        p = product;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; mcand = N'($urandom); mplier = N'($urandom);
            @(posedge clk); #1;
            chk("hold_product", product, p);
            chk("hold_in_ready", in_ready, 1'b0);
            chk("hold_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_consume", in_ready, 1'b1);
        chk("valid_after_consume", out_valid, 1'b0);
        chk("product_retained", product, p);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_product", product, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(1'b1, 8'h80, 8'h80, 0, 16'h4000);
        run_op(1'b0, 8'hFF, 8'hFF, 0, 16'hFE01);
        run_op(1'b1, 8'hFF, 8'hFF, 0, 16'h0001);
        run_op(1'b1, 8'hFF, 8'h01, 0, 16'hFFFF);
        run_op(1'b1, 8'h7F, 8'h80, 0, 16'hC080);
        run_op(1'b0, 8'h00, 8'hC8, 0, 16'h0000);
        run_op(1'b1, 8'h80, 8'h80, 10, 16'h4000);
        // abort mid-calculation
        in_valid = 1'b1; in_signed = 1'b1; mcand = 8'h55; mplier = 8'h66;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_product", product, '0);
        chk("abort_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("abort_no_result", out_valid, 1'b0);
        run_op(1'b1, 8'h07, 8'hFD, 0, 16'hFFEB);
        for (int k = 0; k < 2000; k++) begin
            bit s;
            logic [N-1:0] a, b;
            s = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            run_op(s, a, b, $urandom_range(0, 2), ref_mul(s, a, b));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
